fp_operand_console: RTL and testbench
=====================================

Name: fp_operand_console

Overview:
Parametrised operand-entry and result-display controller for the half-precision pipelined adder datapath. It collects hex digits from the keypad scanner into NUM_OPS=2 operand registers of DIGITS nibbles each, via one-hot digit select or shift-in entry. It launches the adder with a start/done handshake, guarded by a timeout, and drives per-digit hex nibbles plus blank masks to the seven-segment decoders. It sits between keypad_scan, the adder and the display decoders at top level.

Parameters:
DIGITS, 4, nibbles per operand/result; operand width DATA_W = 4*DIGITS.
TIMEOUT, 15, cycles allowed from start to done before the error flag is set (must be >= 1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
key_valid  in  1  one-cycle strobe from the keypad scanner; key_code is valid in the same cycle.
key_code  in  4  hex value of the pressed key.
digit_sel  in  DIGITS  one-hot digit cursor. All-zero selects shift-in entry; multi-hot is illegal.
btn_clear  in  1  level; abort and zero everything.
btn_load_a  in  1  level; enter operand A.
btn_load_b  in  1  level; enter operand B.
btn_run  in  1  level; launch the addition.
op_a  out  DATA_W  operand A to the adder.
op_b  out  DATA_W  operand B to the adder.
start  out  1  one-cycle launch pulse to the adder.
done  in  1  one-cycle completion pulse from the adder.
result  in  DATA_W  adder sum; valid when done=1.
disp_nib  out  4*DIGITS  hex nibble per digit; digit i uses bits [4i+3:4i].
disp_blank  out  DIGITS  1 = digit i dark.
mode  out  3  state code.
busy  out  1  high in WAIT.
timeout_err  out  1  sticky error flag.

Behaviour:
- States and mode codes: IDLE=0, ENTER_A=1, ENTER_B=2, WAIT=3, SHOW=4.
- Reset (asynchronous, rst_n=0) and its outputs:
  - state IDLE; op_a, op_b and the internal result_q are 0.
  - start=0, busy=0, timeout_err=0, disp_nib=0, disp_blank=0.
- Button decode, sampled each clock:
  - btn_clear has absolute priority. It goes to IDLE, zeroes op_a, op_b and result_q, and clears timeout_err, from any state including WAIT.
  - Otherwise a button acts only if exactly one of load_a/load_b/run is high. Zero or several high means no transition.
- Transitions:
  - load_a: to ENTER_A from IDLE, ENTER_B or SHOW.
  - load_b: to ENTER_B from IDLE, ENTER_A or SHOW.
  - run: from IDLE, ENTER_A, ENTER_B or SHOW, assert start for exactly the next cycle, clear timeout_err, load the timeout counter with TIMEOUT and enter WAIT.
  - All buttons except clear are ignored in WAIT. A held run button issues a single start per entry into WAIT; there is no re-trigger until a state change.
- Digit entry (ENTER_A or ENTER_B only, on key_valid; the register updates on the same edge):
  - digit_sel one-hot bit i: the active operand's nibble i <= key_code; other nibbles unchanged.
  - digit_sel == 0: active operand <= {operand[DATA_W-5:0], key_code}, i.e. shift left one nibble with the MSB nibble discarded.
  - digit_sel multi-hot: key ignored.
  - key_valid in IDLE, WAIT or SHOW: ignored.
  - key_valid together with a load button in the same cycle: the key applies to the pre-transition state's operand.
- WAIT:
  - op_a and op_b are frozen.
  - The counter decrements each cycle.
  - done=1: result_q <= result, go to SHOW.
  - Counter reaches 0 without done: timeout_err <= 1, go to SHOW, result_q unchanged.
  - done in the same cycle as expiry: done wins, no error.
  - done outside WAIT (late, or after a clear abort) is ignored.
- Display (registered, one cycle after a state or data change):
  - IDLE: all zeros, unblanked.
  - ENTER_A: op_a. ENTER_B: op_b.
  - WAIT: disp_blank all ones.
  - SHOW: result_q, unblanked.
- busy = (state == WAIT), combinational from the state register. op_a and op_b are registers driven directly.

Decomposition:
- Shared package fp_console_pkg holds the state enum/localparams (IDLE..SHOW, 3-bit) and the DIGITS default, so the top level and the adder wrapper agree on width.
- One natural sub-module: operand_entry_reg. It is a DIGITS-nibble register with write enable, one-hot nibble write and shift-in, instantiated twice (A and B).
- FSM, timeout counter and display mux stay in fp_operand_console.

Test Plan:
- Reset mid-WAIT: assert run, then drop rst_n 2 cycles later. All outputs go to 0 immediately; mode=0; a later done pulse is ignored and result_q stays 0.
- One-hot entry: load_a, then keys 0x5 (sel=0001), 0x3 (0010), 0xC (0100), 0x3 (1000). Required: op_a=16'h3C35, disp_nib=16'h3C35, mode=1.
- Shift entry: load_b, sel=0, keys 1,2,3,4,5. Required: op_b=16'h2345; a multi-hot sel=0011 key press leaves it unchanged.
- Run handshake: A=16'h3C00, B=16'h4000, press run. Required: exactly one start pulse and mode=3 with blanking. Adder returns done with result 16'h4200 three cycles later; then mode=4, disp_nib=16'h4200, timeout_err=0.
- Timeout: run with done never asserted (TIMEOUT=15). After 15 WAIT cycles: mode=4, timeout_err=1. Done coincident with the final count gives no error.
- Button conflicts: load_a+load_b together causes no transition. Clear+run together gives IDLE with no start pulse. Clear in SHOW clears timeout_err and zeroes op_a, op_b and the display.

Source files
------------

// File: rtl/fp_console_pkg.sv
// Shared definitions for the operand console: state codes and default operand size.
package fp_console_pkg;

    localparam int DIGITS_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER_A = 3'd1,
        S_ENTER_B = 3'd2,
        S_WAIT    = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

endpackage

// File: rtl/operand_entry_reg.sv
// DIGITS-nibble operand register with one-hot nibble write or shift-in entry.
module operand_entry_reg
    import fp_console_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  key_en,
    input  logic [DIGITS-1:0]     sel,
    input  logic [3:0]            key_code,
    output logic [4*DIGITS-1:0]   value
);

    logic [4*DIGITS-1:0] value_d;
    logic                sel_onehot;

    assign sel_onehot = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);

    // A multi-hot cursor leaves the operand untouched.
    always_comb begin
        value_d = value;
        if (sel == '0) begin
            value_d = (value << 4) | (4*DIGITS)'(key_code);
        end else if (sel_onehot) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel[i]) value_d[4*i +: 4] = key_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (key_en) begin
            value <= value_d;
        end
    end

endmodule

// File: rtl/fp_operand_console.sv
// Operand entry, adder launch with timeout, and result display controller.
module fp_operand_console
    import fp_console_pkg::*;
#(
    parameter int DIGITS  = DIGITS_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic [DIGITS-1:0]     digit_sel,
    input  logic                  btn_clear,
    input  logic                  btn_load_a,
    input  logic                  btn_load_b,
    input  logic                  btn_run,
    output logic [4*DIGITS-1:0]   op_a,
    output logic [4*DIGITS-1:0]   op_b,
    output logic                  start,
    input  logic                  done,
    input  logic [4*DIGITS-1:0]   result,
    output logic [4*DIGITS-1:0]   disp_nib,
    output logic [DIGITS-1:0]     disp_blank,
    output logic [2:0]            mode,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [4*DIGITS-1:0] result_q;
    logic                launch, capture, expire, btn_one;
    logic                key_en_a, key_en_b;

    // Keys land in the operand of the state the cycle started in.
    assign key_en_a = key_valid && (state_q == S_ENTER_A);
    assign key_en_b = key_valid && (state_q == S_ENTER_B);

    operand_entry_reg #(.DIGITS(DIGITS)) u_reg_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (btn_clear),
        .key_en   (key_en_a),
        .sel      (digit_sel),
        .key_code (key_code),
        .value    (op_a)
    );

    operand_entry_reg #(.DIGITS(DIGITS)) u_reg_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (btn_clear),
        .key_en   (key_en_b),
        .sel      (digit_sel),
        .key_code (key_code),
        .value    (op_b)
    );

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        capture = 1'b0;
        expire  = 1'b0;
        btn_one = ({btn_load_a, btn_load_b, btn_run} == 3'b100) ||
                  ({btn_load_a, btn_load_b, btn_run} == 3'b010) ||
                  ({btn_load_a, btn_load_b, btn_run} == 3'b001);
        if (btn_clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_WAIT: begin
                    // done on the expiry cycle takes precedence over the error
                    if (done) begin
                        capture = 1'b1;
                        state_d = S_SHOW;
                    end else if (cnt_q == CNT_W'(1)) begin
                        expire  = 1'b1;
                        state_d = S_SHOW;
                    end
                end
                default: begin
                    if (btn_one) begin
                        if (btn_load_a && state_q != S_ENTER_A) begin
                            state_d = S_ENTER_A;
                        end else if (btn_load_b && state_q != S_ENTER_B) begin
                            state_d = S_ENTER_B;
                        end else if (btn_run) begin
                            launch  = 1'b1;
                            state_d = S_WAIT;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            start       <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            start   <= launch;
            if (launch) begin
                cnt_q <= CNT_W'(TIMEOUT);
            end else if (state_q == S_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (btn_clear) begin
                result_q <= '0;
            end else if (capture) begin
                result_q <= result;
            end
            if (btn_clear || launch) begin
                timeout_err <= 1'b0;
            end else if (expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_nib   <= '0;
            disp_blank <= '0;
        end else begin
            disp_blank <= '0;
            case (state_q)
                S_ENTER_A: disp_nib <= op_a;
                S_ENTER_B: disp_nib <= op_b;
                S_SHOW:    disp_nib <= result_q;
                S_WAIT: begin
                    disp_nib   <= '0;
                    disp_blank <= '1;
                end
                default:   disp_nib <= '0;
            endcase
        end
    end

    assign busy = (state_q == S_WAIT);
    assign mode = 3'(state_q);

endmodule

// File: tb/tb_fp_operand_console.sv
// Bench for fp_operand_console: directed scenarios plus random traffic against a reference model.
module tb_fp_operand_console;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = '0;
    logic [3:0]  digit_sel = '0;
    logic        btn_clear = 1'b0, btn_load_a = 1'b0, btn_load_b = 1'b0, btn_run = 1'b0;
    logic [15:0] op_a, op_b, result = '0, disp_nib;
    logic        start, done = 1'b0, busy, timeout_err;
    logic [3:0]  disp_blank;
    logic [2:0]  mode;

    int n_pass = 0;
    int n_total = 0;

    fp_operand_console #(.DIGITS(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .digit_sel(digit_sel), .btn_clear(btn_clear), .btn_load_a(btn_load_a),
        .btn_load_b(btn_load_b), .btn_run(btn_run), .op_a(op_a), .op_b(op_b),
        .start(start), .done(done), .result(result), .disp_nib(disp_nib),
        .disp_blank(disp_blank), .mode(mode), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: mode number, operands as plain integers, elapsed wait cycles.
    int          m_mode;
    logic [15:0] m_a, m_b, m_res, m_disp;
    logic [3:0]  m_blank;
    logic        m_start, m_err;
    int          m_elapsed;

    function automatic logic [15:0] apply_key(logic [15:0] op, logic [3:0] k, logic [3:0] sel);
        int idx;
        if (sel == 4'd0) return 16'((int'(op) * 16 + int'(k)) % 65536);
        if ($countones(sel) != 1) return op;
        idx = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
        return (op & ~(16'hF << (4 * idx))) | (16'(k) << (4 * idx));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_a = 0; m_b = 0; m_res = 0; m_disp = 0; m_blank = 0;
            m_start = 0; m_err = 0; m_elapsed = 0;
        end else begin
            int nb;
            m_blank = 4'h0;
            m_disp  = 16'h0;
            if (m_mode == 1) m_disp = m_a;
            if (m_mode == 2) m_disp = m_b;
            if (m_mode == 3) m_blank = 4'hF;
            if (m_mode == 4) m_disp = m_res;
            m_start = 0;
            nb = int'(btn_load_a) + int'(btn_load_b) + int'(btn_run);
            if (key_valid && !btn_clear && m_mode == 1) m_a = apply_key(m_a, key_code, digit_sel);
            if (key_valid && !btn_clear && m_mode == 2) m_b = apply_key(m_b, key_code, digit_sel);
            if (btn_clear) begin
                m_mode = 0; m_a = 0; m_b = 0; m_res = 0; m_err = 0;
            end else if (m_mode == 3) begin
                m_elapsed++;
                if (done) begin
                    m_res = result; m_mode = 4;
                end else if (m_elapsed == TIMEOUT) begin
                    m_err = 1; m_mode = 4;
                end
            end else if (nb == 1) begin
                if (btn_load_a && m_mode != 1) m_mode = 1;
                else if (btn_load_b && m_mode != 2) m_mode = 2;
                else if (btn_run) begin
                    m_mode = 3; m_start = 1; m_err = 0; m_elapsed = 0;
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Compare process: every output against the model on the falling edge.
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m.op_a", 32'(op_a), 32'(m_a));
            check("m.op_b", 32'(op_b), 32'(m_b));
            check("m.start", 32'(start), 32'(m_start));
            check("m.mode", 32'(mode), 32'(m_mode));
            check("m.busy", 32'(busy), 32'(m_mode == 3));
            check("m.err", 32'(timeout_err), 32'(m_err));
            check("m.disp_nib", 32'(disp_nib), 32'(m_disp));
            check("m.disp_blank", 32'(disp_blank), 32'(m_blank));
        end
    end

    // Driver tasks: inputs change 2 time units after the rising edge.
    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(logic c, logic la, logic lb, logic r);
        btn_clear = c; btn_load_a = la; btn_load_b = lb; btn_run = r;
        tick();
        btn_clear = 0; btn_load_a = 0; btn_load_b = 0; btn_run = 0;
    endtask

    task automatic key(logic [3:0] k, logic [3:0] sel);
        key_valid = 1; key_code = k; digit_sel = sel;
        tick();
        key_valid = 0; digit_sel = 4'd0;
    endtask

    task automatic pulse_done(logic [15:0] r);
        done = 1; result = r;
        tick();
        done = 0;
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();
        check("reset.mode", 32'(mode), 32'd0);
        check("reset.op_a", 32'(op_a), 32'd0);
        check("reset.start_busy", 32'({start, busy, timeout_err}), 32'd0);
        check("reset.disp", 32'({disp_nib, disp_blank}), 32'd0);

        // One-hot entry into A
        press(0, 1, 0, 0);
        key(4'h5, 4'b0001); key(4'h3, 4'b0010); key(4'hC, 4'b0100); key(4'h3, 4'b1000);
        tick();
        check("onehot.op_a", 32'(op_a), 32'h3C35);
        check("onehot.disp", 32'(disp_nib), 32'h3C35);
        check("onehot.mode", 32'(mode), 32'd1);

        // Shift entry into B, then a multi-hot key
        press(0, 0, 1, 0);
        for (int k = 1; k <= 5; k++) key(4'(k), 4'b0000);
        check("shift.op_b", 32'(op_b), 32'h2345);
        key(4'h9, 4'b0011);
        tick();
        check("multihot.op_b", 32'(op_b), 32'h2345);
        check("shift.disp", 32'(disp_nib), 32'h2345);

        // Run handshake
        press(0, 1, 0, 0);
        key(4'h3, 4'b0); key(4'hC, 4'b0); key(4'h0, 4'b0); key(4'h0, 4'b0);
        press(0, 0, 1, 0);
        key(4'h4, 4'b0); key(4'h0, 4'b0); key(4'h0, 4'b0); key(4'h0, 4'b0);
        check("run.op_a", 32'(op_a), 32'h3C00);
        check("run.op_b", 32'(op_b), 32'h4000);
        press(0, 0, 0, 1);
        check("run.start", 32'(start), 32'd1);
        check("run.mode", 32'(mode), 32'd3);
        tick();
        check("run.start_once", 32'(start), 32'd0);
        check("run.blank", 32'(disp_blank), 32'hF);
        tick();
        pulse_done(16'h4200);
        tick();
        check("run.show", 32'({mode, disp_nib}), 32'({3'd4, 16'h4200}));
        check("run.err", 32'(timeout_err), 32'd0);

        // Timeout, then done coincident with the last count
        press(0, 0, 0, 1);
        tick(TIMEOUT - 1);
        check("to.still_wait", 32'(mode), 32'd3);
        tick();
        check("to.mode", 32'(mode), 32'd4);
        check("to.err", 32'(timeout_err), 32'd1);
        press(0, 0, 0, 1);
        check("to.run_clears_err", 32'(timeout_err), 32'd0);
        tick(TIMEOUT - 1);
        pulse_done(16'h1234);
        check("edge.err", 32'({mode, 1'b0, timeout_err}), 32'({3'd4, 2'b00}));
        tick();
        check("edge.disp", 32'(disp_nib), 32'h1234);

        // Button conflicts
        press(0, 1, 1, 0);
        check("conf.ab", 32'(mode), 32'd4);
        press(0, 0, 0, 1);
        tick(TIMEOUT);
        check("conf.err_set", 32'(timeout_err), 32'd1);
        press(1, 0, 0, 0);
        check("clear.state", 32'({mode, timeout_err}), 32'd0);
        check("clear.ops", 32'({op_a, op_b}), 32'd0);
        tick();
        check("clear.disp", 32'(disp_nib), 32'd0);
        press(1, 0, 0, 1);
        check("clear_run", 32'({mode, start}), 32'd0);

        // Reset in the middle of WAIT
        press(0, 1, 0, 0);
        key(4'h7, 4'b0001);
        press(0, 0, 0, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst.outs", 32'({mode, start, busy, timeout_err}), 32'd0);
        check("rst.ops", 32'({op_a, op_b}), 32'd0);
        check("rst.disp", 32'({disp_nib, disp_blank}), 32'd0);
        tick();
        rst_n = 1'b1;
        pulse_done(16'hBEEF);
        check("rst.late_done", 32'(mode), 32'd0);
        press(0, 0, 0, 1);
        tick(TIMEOUT + 1);
        check("rst.result_q", 32'(disp_nib), 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            btn_clear  = ($urandom_range(0, 59) == 0);
            btn_load_a = ($urandom_range(0, 9) == 0);
            btn_load_b = ($urandom_range(0, 9) == 0);
            btn_run    = ($urandom_range(0, 11) == 0);
            key_valid  = $urandom_range(0, 1) == 1;
            key_code   = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       digit_sel = 4'd0;
                1:       digit_sel = 4'($urandom);
                default: digit_sel = 4'(1 << $urandom_range(0, 3));
            endcase
            done   = ($urandom_range(0, 12) == 0);
            result = 16'($urandom);
            tick();
        end
        btn_clear = 0; btn_load_a = 0; btn_load_b = 0; btn_run = 0;
        key_valid = 0; done = 0;
        tick(2);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
